// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port 32-bit RAM.
// Port A is instruction fetch, port B is data. Every access takes two
// cycles: the request is presented to the RAM in IDLE, and the ack carries
// the RAM's registered read data in the following cycle.
//
// Optional feature: define RAM_ARB_RR_EN to share simultaneous requests
// round-robin through a 1-bit last-grant register. Without it, port B
// always wins a tie and no last-grant register is built.
//
// state | meaning
// IDLE  | no access in flight; the winning request is driven onto the RAM
// ACK_A | RAM read data belongs to port A; ack A for this one cycle
// ACK_B | RAM read data belongs to port B; ack B for this one cycle

module ram_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,

  input  logic              a_stb_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_adr_i,
  input  logic [3:0]        a_sel_i,
  input  logic [31:0]       a_dat_i,
  output logic [31:0]       a_dat_o,
  output logic              a_ack_o,

  input  logic              b_stb_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_adr_i,
  input  logic [3:0]        b_sel_i,
  input  logic [31:0]       b_dat_i,
  output logic [31:0]       b_dat_o,
  output logic              b_ack_o,

  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [3:0]        ram_be_o,
  output logic [31:0]       ram_dat_o,
  input  logic [31:0]       ram_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK_A = 2'd1,
    S_ACK_B = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_grant_a;
  logic w_grant_b;
  logic w_ram_we;

`ifdef RAM_ARB_RR_EN
  // 1 when B received the most recent grant; reset value gives B priority.
  logic r_last_b;

  // Record the winner every time a request is accepted in IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_last_b <= 1'b0;
    end else if (r_state == S_IDLE && (a_stb_i || b_stb_i)) begin
      r_last_b <= w_grant_b;
    end
  end

  // On a tie B wins unless it was the last port served.
  assign w_grant_b = b_stb_i && (!a_stb_i || !r_last_b);
`else
  // Fixed priority: B wins every tie.
  assign w_grant_b = b_stb_i;
`endif

  assign w_grant_a = a_stb_i && !w_grant_b;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: accept one request in IDLE, always return after the ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_b) begin
          w_state_nxt = S_ACK_B;
        end else if (w_grant_a) begin
          w_state_nxt = S_ACK_A;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK_A: w_state_nxt = S_IDLE;
      S_ACK_B: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: RAM request mux in IDLE, ack and read-data return in ACK_x.
  // Acks are suppressed while reset is low so an interrupted access is
  // abandoned rather than completed.
  always_comb begin
    w_ram_we  = 1'b0;
    ram_adr_o = '0;
    ram_be_o  = 4'h0;
    ram_dat_o = 32'h0;
    a_ack_o   = 1'b0;
    b_ack_o   = 1'b0;
    a_dat_o   = 32'h0;
    b_dat_o   = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_b) begin
          w_ram_we  = b_we_i;
          ram_adr_o = b_adr_i;
          ram_be_o  = b_sel_i;
          ram_dat_o = b_dat_i;
        end else if (w_grant_a) begin
          w_ram_we  = a_we_i;
          ram_adr_o = a_adr_i;
          ram_be_o  = a_sel_i;
          ram_dat_o = a_dat_i;
        end
      end
      S_ACK_A: begin
        if (rst_n_i) begin
          a_ack_o = 1'b1;
          a_dat_o = ram_dat_i;
        end
      end
      S_ACK_B: begin
        if (rst_n_i) begin
          b_ack_o = 1'b1;
          b_dat_o = ram_dat_i;
        end
      end
      default: ;
    endcase
  end

  // No write may reach the RAM while reset is held.
  assign ram_we_o = w_ram_we & rst_n_i;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 12, word-address width of the RAM and of both requester ports.
REQ-002 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 Port: a_stb_i / a_we_i  input  1 / 1  port A (instruction fetch) request strobe / write enable.
REQ-005 Port: a_adr_i  input  ADDR_W  port A word address.
REQ-006 Port: a_sel_i  input  4  port A byte enables; a_dat_i  input  32  port A write data.
REQ-007 Port: a_dat_o  output  32  port A read data; a_ack_o  output  1  port A access complete.
REQ-008 Port: b_stb_i, b_we_i, b_adr_i, b_sel_i, b_dat_i, b_dat_o, b_ack_o; same widths and meaning for port B (data).
REQ-009 Port: ram_we_o  output  1; ram_adr_o  output  ADDR_W; ram_be_o  output  4; ram_dat_o  output  32; these drive the single-port RAM.
REQ-010 Port: ram_dat_i  input  32  RAM registered read data, valid one cycle after the address is presented.

Function
REQ-011 The FSM SHALL have states IDLE, ACK_A, ACK_B.
REQ-012 In IDLE with no stb asserted, the RAM outputs SHALL be we=0, adr=0, be=0, dat=0, and the FSM SHALL stay in IDLE.
REQ-013 In IDLE with stb asserted, the winner's we/adr/sel/dat SHALL be driven combinationally onto the RAM port in that same cycle, and the FSM SHALL move to ACK_A or ACK_B.
REQ-014 In ACK_x the arbiter SHALL assert x_ack_o for exactly one cycle and drive x_dat_o = ram_dat_i, for reads and writes alike.
REQ-015 In ACK_x the RAM outputs SHALL be idle values (we=0), and the next state SHALL be IDLE unconditionally.
REQ-016 A requester SHALL hold stb and its qualifiers stable until ack, and drop stb the cycle after ack; this yields one access per 2 cycles.
REQ-017 The non-acked port's dat_o SHALL be 0x00000000, and its ack_o SHALL be 0.
REQ-018 A requester that loses arbitration SHALL remain pending and no request SHALL be dropped.
REQ-019 A write SHALL only modify the bytes whose sel bit is 1; sel=0000 with we=1 SHALL still complete with ack.
REQ-020 Arbitration on simultaneous a_stb_i and b_stb_i SHALL follow REQ-026/REQ-027.
REQ-021 Addresses SHALL pass through unmodified; there is no range check.

Reset
REQ-022 While rst_n_i=0 at a rising edge, the FSM SHALL go to IDLE and both ack_o SHALL be 0 in the following cycle.
REQ-023 While rst_n_i=0, ram_we_o SHALL be forced to 0 combinationally, so no write reaches the RAM during reset.
REQ-024 A reset asserted while in ACK_x SHALL abandon the access with no ack; the requester re-issues it.
REQ-025 Reset SHALL restore the round-robin pointer to "B has priority", and all dat_o SHALL read 0 after reset.

Configuration
REQ-026 With RAM_ARB_RR_EN defined, simultaneous requests SHALL go to the port not granted most recently, using a 1-bit last-grant register updated on each grant.
REQ-027 Without RAM_ARB_RR_EN, port B SHALL always win simultaneous requests, and no last-grant register SHALL exist.

Verification
REQ-028 Scenario: A write adr=0x010, sel=1111, dat=0xDEADBEEF; then A read adr=0x010 -> ram_we_o=1 for one cycle; the read's a_ack_o comes one cycle after the request with a_dat_o=0xDEADBEEF.
REQ-029 Scenario: B write adr=0x020, sel=0010, dat=0x0000AB00 over a word holding 0x11223344; then B read -> b_dat_o=0x1122AB44.
REQ-030 Scenario: a_stb_i and b_stb_i rise together and both are held for 4 accesses -> with RAM_ARB_RR_EN the grant order is B,A,B,A; without it the order is B,B,... while b_stb_i is held, and A is served once B drops.
REQ-031 Scenario: rst_n_i pulsed low for 1 cycle while in ACK_A -> no a_ack_o; ram_we_o=0 during reset; FSM is IDLE the next cycle.
REQ-032 Scenario: back-to-back A reads to adr 0x000..0x003 -> 4 acks, spaced every 2 cycles, with b_ack_o=0 and b_dat_o=0 throughout.
